axi_ram_arbiter: RTL

//  Shares the single AXI4 RAM slave port between the fetch stage (m0, read-only) and the

---
 rtl/axi_arb_pkg.sv | 9 +
 rtl/rr_arbiter2.sv | 20 ++
 rtl/axi_ram_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and widths for the AXI RAM arbiter
package axi_arb_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_AR, S_RWAIT, S_WR, S_B, S_DONE} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; last_gnt moves only when update is high
module rr_arbiter2
    import axi_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic last_gnt;
    assign gnt[0] = req[0] & (~req[1] | last_gnt);
    assign gnt[1] = req[1] & (~req[0] | ~last_gnt);
    always_ff @(posedge clock) begin
        if (reset)
            last_gnt <= ID_M1;
        else if (update && |gnt)
            last_gnt <= gnt[1];
    end
endmodule

// File: rtl/axi_ram_arbiter.sv
// axi_ram_arbiter: shares one AXI4 RAM port between fetch (m0) and LSU (m1), with watchdog abort
module axi_ram_arbiter
    import axi_arb_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wen,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] ram_awaddr,
    output logic              ram_awvalid,
    input  logic              ram_awready,
    output logic [ADDR_W-1:0] ram_araddr,
    output logic              ram_arvalid,
    input  logic              ram_arready,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [STRB_W-1:0] ram_wstrb,
    output logic              ram_wvalid,
    input  logic              ram_wready,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_bvalid
);
    state_t            state, state_n;
    logic              id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              aw_done, w_done, abort;
    logic [31:0]       rcnt, wd;
    logic [1:0]        gnt;
    logic              aw_fin, w_fin, rlast, busy, timeout;

    rr_arbiter2 u_arb (
        .clock (clock),
        .reset (reset),
        .req   ({m1_req, m0_req}),
        .update(state == S_IDLE),
        .gnt   (gnt)
    );

    assign aw_fin  = aw_done | ram_awready;
    assign w_fin   = w_done | ram_wready;
    assign rlast   = rcnt == 32'(READ_LAT - 1);
    assign busy    = state inside {S_AR, S_RWAIT, S_WR, S_B};
    assign timeout = (TIMEOUT != 0) && busy && (wd >= 32'(TIMEOUT - 1));

    assign ram_araddr  = addr;
    assign ram_awaddr  = addr;
    assign ram_wdata   = wdata;
    assign ram_wstrb   = wstrb;
    assign ram_arvalid = state == S_AR;
    assign ram_awvalid = state == S_WR && !aw_done;
    assign ram_wvalid  = state == S_WR && !w_done;
    assign m0_done     = state == S_DONE && id == ID_M0;
    assign m1_done     = state == S_DONE && id == ID_M1;
    assign err         = state == S_DONE && abort;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (|gnt) state_n = (gnt[1] && m1_wen) ? S_WR : S_AR;
            S_AR:    if (ram_arready) state_n = S_RWAIT;
            S_RWAIT: if (rlast) state_n = S_DONE;
            S_WR:    if (aw_fin && w_fin) state_n = ram_bvalid ? S_DONE : S_B;
            S_B:     if (ram_bvalid) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (timeout) state_n = S_DONE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            id       <= ID_M1;
            addr     <= '0;
            wdata    <= '0;
            wstrb    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            abort    <= 1'b0;
            rcnt     <= '0;
            wd       <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            state <= state_n;
            // watchdog saturates at all-ones instead of wrapping
            wd <= (state == S_IDLE) ? '0 : wd + {31'b0, ~&wd};
            if (state == S_IDLE) begin
                id      <= gnt[1];
                addr    <= gnt[1] ? m1_addr : m0_addr;
                wdata   <= m1_wdata;
                wstrb   <= m1_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                abort   <= 1'b0;
                rcnt    <= '0;
            end
            if (state == S_WR) begin
                aw_done <= aw_fin;
                w_done  <= w_fin;
            end
            if (state == S_RWAIT) rcnt <= rcnt + 32'd1;
            if (state == S_RWAIT && rlast) begin
                if (id) m1_rdata <= ram_rdata;
                else    m0_rdata <= ram_rdata;
            end
            if (timeout) begin
                abort <= 1'b1;
                if (id) m1_rdata <= '0;
                else    m0_rdata <= '0;
            end
        end
    end
endmodule
